mem_req_arbiter: RTL and testbench
==================================

# mem_req_arbiter

Two-requester round-robin arbiter that shares the single `memory_interface` data-memory port between requester 0 (load/store unit) and requester 1 (fill/DMA path). It latches the granted request and issues a one-cycle `enable` pulse to the memory interface. It then waits for that interface's `done` pulse, captures the read data, and returns a one-cycle acknowledge to the owning requester. It sits between the pipeline memory stage and `memory_interface`.

## Interface
- ADDR_W, 14, address width; matches `addr_mem`.
- DATA_W, 64, data width; matches `data_mem_in`/`data_mem_out`.
- TIMEOUT_CYC, 32, WAIT-state cycle limit; used only with MEM_ARB_TIMEOUT_EN; range 1..255.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req0, req1  in  1  request; held high until the matching ack.
- we0, we1  in  1  1 = write, 0 = read.
- addr0, addr1  in  ADDR_W  request address.
- wdata0, wdata1  in  DATA_W  write data.
- ack0, ack1  out  1  one-cycle completion pulse.
- rdata0, rdata1  out  DATA_W  read data; valid from ack and held until the next read ack to that requester.
- err0, err1  out  1  one-cycle timeout pulse; constant 0 without MEM_ARB_TIMEOUT_EN.
- busy  out  1  high in ISSUE and WAIT.
- mem_en  out  1  to `enable`; one-cycle pulse.
- mem_wr  out  1  to `rd_wrt_mem` (1 = write).
- mem_addr  out  ADDR_W  to `addr_mem`.
- mem_wdata  out  DATA_W  to `data_mem_in`.
- mem_rdata  in  DATA_W  from `data_mem_out`; valid only while mem_done = 1.
- mem_done  in  1  from `done`.

## Operation
- States: IDLE, ISSUE, WAIT.
- **IDLE**
  - If neither req is high, stay in IDLE.
  - Otherwise grant one requester:
    - Single request: grant it.
    - Both: grant the requester not named by `last` (`last` = 0 after reset, so req1 wins the first tie).
  - On grant, register gnt_id, we, addr and wdata into the mem_* registers, then go to ISSUE.
- **ISSUE**
  - mem_en = 1 for exactly this cycle; go to WAIT.
- **WAIT**
  - mem_en = 0; mem_addr, mem_wr and mem_wdata stay stable.
  - On mem_done = 1:
    - If the transaction is a read, load mem_rdata into rdata[gnt_id]; a write leaves rdata unchanged.
    - Pulse ack[gnt_id] in the next cycle (registered).
    - Set last ← gnt_id; go to IDLE.
- Arbitration and requester rules:
  - Requests are sampled only in IDLE.
  - A req that drops before its grant is ignored.
  - req still high in the cycle after its ack is treated as a new request.
  - mem_done seen in IDLE or ISSUE is ignored; it causes no ack and no state change.
  - Requester inputs are not re-sampled after grant, so changes to them during ISSUE/WAIT have no effect.
- Reset (asynchronous, any state, including mid-transaction):
  - State ← IDLE; last ← 0.
  - All outputs and the rdata registers ← 0.
  - In-flight transaction is dropped without an ack.

## Timing
- Fixed arbiter overhead is 2 cycles: one from req sampled to mem_en, one from mem_done to ack.
- With the current memory interface, a req first sampled in IDLE at cycle 0 gives:
  - mem_en in cycle 1.
  - Write: mem_done in cycle 6, ack in cycle 7.
  - Read: mem_done in cycle 7, ack in cycle 8.
- Minimum one IDLE cycle between back-to-back grants. Peak rate is one transaction per 8 cycles for writes and 9 for reads.
- ack and err are mutually exclusive, and at most one requester is acked or errored per cycle.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If TIMEOUT_CYC WAIT cycles elapse without mem_done, pulse err[gnt_id] (no ack), leave rdata unchanged, set last ← gnt_id, go to IDLE.
  - A mem_done in the same cycle as expiry wins and gives a normal ack.
- Not defined: WAIT lasts until mem_done indefinitely; err0/err1 are tied 0 and there is no counter.

## Test plan
- Reset mid-WAIT: assert rst low during WAIT → all outputs 0 immediately; no ack after release; next req0 served normally.
- Single write: req0 = 1, we0 = 1, addr0 = 14'h0010, wdata0 = 64'hDEAD_BEEF_0000_0001 → mem_en pulse in cycle 1, ack0 in cycle 7, ack1 stays 0.
- Readback: req1 read of 14'h0010 after the write above → ack1 in cycle 8; rdata1 = 64'hDEAD_BEEF_0000_0001 and held after ack.
- Contention: req0 and req1 both high from reset and held → grant order 1, 0, 1, 0; mem_addr matches the granted requester; no overlapping mem_en.
- Spurious done: mem_done pulsed in IDLE with no req → no ack/err; state stays IDLE.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYC = 4, mem_done held 0) → err0 pulse after 4 WAIT cycles, no ack0; arbiter returns to IDLE.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: two-requester round-robin arbiter in front of the single
// data-memory port (memory_interface). Requester 0 is the load/store unit and
// requester 1 is the fill/DMA path. Each granted request is latched into the
// mem_* registers, issued with a one-cycle enable, and completed with a
// registered one-cycle ack to the owner when the interface returns done.
//
// Optional build macro: MEM_ARB_TIMEOUT_EN
//    When defined, a WAIT-state watchdog of TIMEOUT_CYC cycles aborts a
//    transaction and pulses err[gnt_id] instead of ack. When undefined,
//    WAIT lasts until mem_done and err0/err1 are tied low.
//
// state | meaning
// IDLE  | no transaction in flight; sample requests and grant
// ISSUE | mem_en pulse to the memory interface
// WAIT  | hold mem_addr/mem_wr/mem_wdata until mem_done (or timeout)

module mem_req_arbiter #(
   parameter int ADDR_W      = 14,
   parameter int DATA_W      = 64,
   parameter int TIMEOUT_CYC = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              err0,
   output logic              err1,
   output logic              busy,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic last;
   logic gnt_id;
   logic grant;
   logic gnt_sel;
   logic done_hit;
   logic pulse_q;

   // While an ack/err pulse is out, the owner may still be holding req, so
   // that IDLE cycle never grants; this gives the one-cycle gap between grants.
   assign pulse_q = ack0 | ack1 | err0 | err1;

   assign mem_en = (state == ISSUE);
   assign busy   = (state != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

   logic [7:0] to_cnt;
   logic       timeout_hit;

   // WAIT-cycle counter: cleared while in ISSUE so it reads 0 on WAIT entry
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         to_cnt <= 8'd0;
      end else if (state == ISSUE) begin
         to_cnt <= 8'd0;
      end else if (state == WAIT) begin
         to_cnt <= to_cnt + 8'd1;
      end
   end
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, grant selection and completion detection
   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      gnt_sel   = 1'b0;
      done_hit  = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (!pulse_q && (req0 || req1)) begin
               grant     = 1'b1;
               gnt_sel   = (req0 && req1) ? ~last : req1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            state_nxt = WAIT;
         end
         WAIT: begin
            // done takes priority over an expiring watchdog in the same cycle
            if (mem_done) begin
               done_hit  = 1'b1;
               state_nxt = IDLE;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (to_cnt == TO_LAST) begin
               timeout_hit = 1'b1;
               state_nxt   = IDLE;
            end
`endif
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Request capture, read-data capture and registered ack/err pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last      <= 1'b0;
         gnt_id    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata0    <= '0;
         rdata1    <= '0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         err0      <= 1'b0;
         err1      <= 1'b0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         err0 <= 1'b0;
         err1 <= 1'b0;
         if (grant) begin
            gnt_id    <= gnt_sel;
            mem_wr    <= gnt_sel ? we1    : we0;
            mem_addr  <= gnt_sel ? addr1  : addr0;
            mem_wdata <= gnt_sel ? wdata1 : wdata0;
         end
         if (done_hit) begin
            ack0 <= ~gnt_id;
            ack1 <= gnt_id;
            last <= gnt_id;
            if (!mem_wr) begin
               if (gnt_id) begin
                  rdata1 <= mem_rdata;
               end else begin
                  rdata0 <= mem_rdata;
               end
            end
         end
`ifdef MEM_ARB_TIMEOUT_EN
         if (timeout_hit) begin
            err0 <= ~gnt_id;
            err1 <= gnt_id;
            last <= gnt_id;
         end
`endif
      end
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed testbench for mem_req_arbiter with a small memory-interface model:
// done arrives 5 cycles after enable for writes and 6 for reads.

module tb_mem_req_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int TO_CYC = 4;
`else
   localparam int TO_CYC = 32;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic        we0 = 1'b0, we1 = 1'b0;
   logic [13:0] addr0 = '0, addr1 = '0;
   logic [63:0] wdata0 = '0, wdata1 = '0;
   logic        ack0, ack1, err0, err1, busy;
   logic [63:0] rdata0, rdata1;
   logic        mem_en, mem_wr, mem_done;
   logic [13:0] mem_addr;
   logic [63:0] mem_wdata, mem_rdata;

   logic        stall = 1'b0;
   logic        spur = 1'b0;
   int          mcnt;
   logic [63:0] mem_model [0:255];

   int n_checks = 0;
   int n_errors = 0;
   int overlap_cnt = 0;
   int multi_cnt = 0;
   logic prev_en;

   mem_req_arbiter #(.ADDR_W(14), .DATA_W(64), .TIMEOUT_CYC(TO_CYC)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .err0(err0), .err1(err1), .busy(busy),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done)
   );

   always #5 clk = ~clk;

   // memory interface model
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mcnt <= 0;
      end else if (mem_en) begin
         mcnt <= mem_wr ? 5 : 6;
      end else if (mcnt != 0) begin
         mcnt <= mcnt - 1;
         if (mcnt == 1 && !stall && mem_wr) mem_model[mem_addr[7:0]] <= mem_wdata;
      end
   end

   assign mem_done  = ((mcnt == 1) && !stall) || spur;
   assign mem_rdata = mem_done ? mem_model[mem_addr[7:0]] : 64'h0;

   // protocol monitors: no back-to-back enables, at most one ack/err per cycle
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_en <= 1'b0;
      end else begin
         prev_en <= mem_en;
         if (mem_en && prev_en) overlap_cnt <= overlap_cnt + 1;
         if ((32'(ack0) + 32'(ack1) + 32'(err0) + 32'(err1)) > 1) multi_cnt <= multi_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request starting now (cycle 0); who = 0/1 ack, 2/3 err, -1 none
   task automatic issue(input int rq, input logic we, input logic [13:0] a,
                        input logic [63:0] d, output int en_c, output int done_c,
                        output int who);
      en_c = -1; done_c = -1; who = -1;
      if (rq == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
      else         begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
      for (int c = 1; c <= 60; c++) begin
         tick();
         if (mem_en && en_c < 0) en_c = c;
         if (ack0 | ack1 | err0 | err1) begin
            done_c = c;
            who = ack0 ? 0 : ack1 ? 1 : err0 ? 2 : 3;
            break;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();
   endtask

   int en_c, done_c, who, pulses, busy_seen, n_ack;
   int ack_c [4];
   int ack_who [4];
   logic [13:0] ack_addr [4];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      // reset state
      tick(); tick();
      check("rst_ack0", ack0, 0);
      check("rst_ack1", ack1, 0);
      check("rst_busy", busy, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_rdata0", rdata0, 0);
      rst = 1'b1;
      tick();

      // reset in the middle of WAIT
      req0 = 1'b1; we0 = 1'b0; addr0 = 14'h0005;
      tick(); tick(); tick();
      check("midwait_busy", busy, 1);
      check("midwait_addr", mem_addr, 14'h0005);
      rst = 1'b0;
      #1;
      check("rst_async_busy", busy, 0);
      check("rst_async_addr", mem_addr, 0);
      req0 = 1'b0;
      tick(); tick();
      rst = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (ack0 | ack1 | err0 | err1) pulses++;
      end
      check("no_ack_after_rst", pulses, 0);

      // single write from requester 0
      issue(0, 1'b1, 14'h0010, 64'hDEAD_BEEF_0000_0001, en_c, done_c, who);
      check("wr_en_cycle", en_c, 1);
      check("wr_ack_cycle", done_c, 7);
      check("wr_ack_who", who, 0);

      // readback from requester 1
      issue(1, 1'b0, 14'h0010, 64'h0, en_c, done_c, who);
      check("rd_en_cycle", en_c, 1);
      check("rd_ack_cycle", done_c, 8);
      check("rd_ack_who", who, 1);
      check("rd_rdata1", rdata1, 64'hDEAD_BEEF_0000_0001);
      check("rd_rdata0_untouched", rdata0, 0);
      tick(); tick(); tick();
      check("rd_rdata1_held", rdata1, 64'hDEAD_BEEF_0000_0001);

      // a write by requester 1 leaves rdata1 alone
      issue(1, 1'b1, 14'h0011, 64'h0000_1234_5678_9ABC, en_c, done_c, who);
      check("wr1_ack_cycle", done_c, 7);
      check("wr1_rdata1_kept", rdata1, 64'hDEAD_BEEF_0000_0001);

      // spurious done in IDLE
      spur = 1'b1;
      tick();
      spur = 1'b0;
      pulses = 0; busy_seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (ack0 | ack1 | err0 | err1) pulses++;
         if (busy) busy_seen++;
      end
      check("spur_no_pulse", pulses, 0);
      check("spur_stay_idle", busy_seen, 0);
      issue(0, 1'b0, 14'h0011, 64'h0, en_c, done_c, who);
      check("post_spur_en", en_c, 1);
      check("post_spur_ack", done_c, 8);
      check("post_spur_rdata0", rdata0, 64'h0000_1234_5678_9ABC);

      // contention from reset: grant order 1,0,1,0
      rst = 1'b0;
      tick(); tick();
      rst = 1'b1;
      req0 = 1'b1; we0 = 1'b1; addr0 = 14'h0020; wdata0 = 64'hA0;
      req1 = 1'b1; we1 = 1'b1; addr1 = 14'h0030; wdata1 = 64'hB1;
      n_ack = 0;
      for (int c = 1; c <= 80 && n_ack < 4; c++) begin
         tick();
         if (ack0 | ack1) begin
            ack_c[n_ack] = c;
            ack_who[n_ack] = ack1 ? 1 : 0;
            ack_addr[n_ack] = mem_addr;
            n_ack++;
            if (n_ack == 4) begin req0 = 1'b0; req1 = 1'b0; end
         end
      end
      check("cont_n_ack", n_ack, 4);
      check("cont_who0", ack_who[0], 1);
      check("cont_who1", ack_who[1], 0);
      check("cont_who2", ack_who[2], 1);
      check("cont_who3", ack_who[3], 0);
      check("cont_addr0", ack_addr[0], 14'h0030);
      check("cont_addr1", ack_addr[1], 14'h0020);
      check("cont_c0", ack_c[0], 7);
      check("cont_c3", ack_c[3], 31);
      tick();

`ifdef MEM_ARB_TIMEOUT_EN
      // timeout with mem_done held low
      stall = 1'b1;
      issue(0, 1'b1, 14'h0040, 64'h55, en_c, done_c, who);
      stall = 1'b0;
      check("to_en_cycle", en_c, 1);
      check("to_err_cycle", done_c, 6);
      check("to_err_who", who, 2);
      issue(1, 1'b1, 14'h0041, 64'h66, en_c, done_c, who);
      check("to_recover_en", en_c, 1);
      check("to_recover_ack", done_c, 7);
      check("to_recover_who", who, 1);
`endif

      check("no_en_overlap", overlap_cnt, 0);
      check("single_pulse", multi_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
